bsram_sequencer: RTL

Owns the single-port program BSRAM (Gowin_SP) and decides, cycle by cycle, who drives it. After reset it copies a fixed boot image into the BSRAM. It then gives the port to CPU instruction fetch, and lets the UART program loader interrupt fetch for single-word writes. It sits between the BSRAM instance, the CPU's `adr`/`dout` pins and the UART loader in `top`.

---
 rtl/bsram_sequencer_if.sv | 14 +
 rtl/bsram_sequencer.sv | 96 +++++++++
 2 files changed

// File: rtl/bsram_sequencer_if.sv
// bsram_sequencer_if: UART loader write handshake into the BSRAM sequencer
// master = loader: drives ld_req (level, held until ack), ld_addr, ld_data; samples ld_ack
// slave  = sequencer: samples request/address/data; drives one-cycle ld_ack
interface bsram_sequencer_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ack;
    modport master (output ld_req, ld_addr, ld_data, input ld_ack);
    modport slave  (input ld_req, ld_addr, ld_data, output ld_ack);
endinterface

// File: rtl/bsram_sequencer.sv
// bsram_sequencer: owns the single-port program BSRAM; boot copy, then CPU fetch with loader writes
// clk/rst_n          : clock, asynchronous active-low reset
// boot_idx/boot_word : boot-image ROM address out, combinational word back
// ld                 : loader write handshake (slave side)
// cpu_adr/cpu_dout   : fetch address in, fetched instruction out
// cpu_hold/boot_done : stall CPU outside RUN; sticky boot-complete flag
// mem_*              : BSRAM port (registered read, 1-cycle latency)
module bsram_sequencer #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16,
    parameter int BOOT_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] boot_idx,
    input  logic [DATA_W-1:0] boot_word,
    bsram_sequencer_if.slave  ld,
    input  logic [ADDR_W-1:0] cpu_adr,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_hold,
    output logic              boot_done,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);
    typedef enum logic [2:0] {BOOT_WR, BOOT_NEXT, RUN, LD_WR, LD_GAP} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BOOT_LEN - 1);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d, la_q, la_d;
    logic [DATA_W-1:0] lw_q, lw_d, dout_q, dout_d;
    logic              done_q, done_d, run_q, run_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT_WR;
            idx_q   <= '0;
            la_q    <= '0;
            lw_q    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            la_q    <= la_d;
            lw_q    <= lw_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            run_q   <= run_d;
        end
    end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        la_d    = la_q;
        lw_d    = lw_q;
        done_d  = done_q;
        // run_q marks that the previous cycle issued a fetch read, so mem_dout is an instruction
        run_d   = state_q == RUN;
        dout_d  = run_q ? mem_dout : dout_q;
        case (state_q)
            BOOT_WR:   state_d = BOOT_NEXT;
            BOOT_NEXT: begin
                if (idx_q == LAST) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else begin
                    state_d = BOOT_WR;
                    idx_d   = idx_q + 1'b1;
                end
            end
            RUN: begin
                if (ld.ld_req) begin
                    state_d = LD_WR;
                    la_d    = ld.ld_addr;
                    lw_d    = ld.ld_data;
                end
            end
            LD_WR:     state_d = LD_GAP;
            default:   state_d = RUN;
        endcase
    end
    always_comb begin
        mem_ce    = 1'b1;
        mem_wre   = state_q == BOOT_WR || state_q == LD_WR;
        ld.ld_ack = state_q == LD_WR;
        cpu_hold  = state_q != RUN;
        mem_ad    = (state_q == BOOT_WR || state_q == BOOT_NEXT) ? idx_q :
                    state_q == LD_WR ? la_q : cpu_adr;
        mem_din   = state_q == LD_WR ? lw_q : boot_word;
    end
    assign boot_idx  = idx_q;
    assign boot_done = done_q;
    assign cpu_dout  = dout_q;
endmodule
